chan_fifo_bridge: RTL and testbench

Parametrised multi-FIFO bridge between the comm_fpga channel interface and application logic, all on one clock. It instantiates NUM_PAIRS FIFO pairs. Each pair has a host→application write FIFO and an application→host read FIFO, plus per-pair status/control channels. Added behaviour: per-FIFO flush, and a sticky overflow flag on the application producer side.

---
 rtl/chan_fifo_bridge_pkg.sv | 32 +++
 rtl/chan_fifo_bridge_fifo_sync.sv | 57 +++++
 rtl/chan_fifo_bridge.sv | 111 +++++++++++
 tb/tb_chan_fifo_bridge.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_fifo_bridge_pkg.sv
// Shared definitions for the channel FIFO bridge.
// Flush/ovf bit positions and per-pair channel map.
package chan_fifo_bridge_pkg;

  localparam int FLUSH_WR = 0;
  localparam int FLUSH_RD = 1;
  localparam int OVF_BIT  = 7;

  function automatic logic [6:0] chanD(
    input int base,
    input int k
  );
    return 7'(base + k);
  endfunction

  function automatic logic [6:0] chanSW(
    input int base,
    input int np,
    input int k
  );
    return 7'(base + np + 2 * k);
  endfunction

  function automatic logic [6:0] chanSR(
    input int base,
    input int np,
    input int k
  );
    return 7'(base + np + 2 * k + 1);
  endfunction

endpackage

// File: rtl/chan_fifo_bridge_fifo_sync.sv
// First-word-fall-through byte FIFO with flush and occupancy count.
// Push while full is accepted only alongside a pop.
module fifo_sync #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic [7:0]          din,
  input  logic                wr_en,
  output logic                full,
  output logic [7:0]          dout,
  input  logic                rd_en,
  output logic                empty,
  input  logic                flush_in,
  output logic [DEPTH_LOG2:0] count_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic [DEPTH_LOG2:0]   count;
  logic                  doPush;
  logic                  doPop;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign empty     = (count == '0);
  assign full      = count[DEPTH_LOG2];
  assign count_out = count;
  assign dout      = mem[rdPtr];
  assign doPop     = rd_en && !empty;
  assign doPush    = wr_en && (!full || doPop);

  always_ff @(posedge clk_in) begin
    if (!reset_in || flush_in) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush)
        wrPtr <= wrPtr + 1'b1;
      if (doPop)
        rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop)
        count <= count + 1'b1;
      else if (doPop && !doPush)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (doPush && !flush_in)
      mem[wrPtr] <= din;
  end

endmodule

// File: rtl/chan_fifo_bridge.sv
// Host channel <-> application bridge: NUM_PAIRS FIFO pairs with
// status/flush channels and a sticky read-side overflow flag.
module chan_fifo_bridge
  import chan_fifo_bridge_pkg::*;
#(
  parameter int NUM_PAIRS  = 2,
  parameter int DEPTH_LOG2 = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic [6:0]             hostAddr_in,
  input  logic [7:0]             hostData_in,
  input  logic                   hostWrite_in,
  output logic                   hostGotRoom_out,
  output logic [7:0]             hostData_out,
  input  logic                   hostRead_in,
  output logic                   hostGotData_out,
  output logic [8*NUM_PAIRS-1:0] wrData_out,
  output logic [NUM_PAIRS-1:0]   wrValid_out,
  input  logic [NUM_PAIRS-1:0]   wrReady_in,
  input  logic [8*NUM_PAIRS-1:0] rdData_in,
  input  logic [NUM_PAIRS-1:0]   rdValid_in,
  output logic [NUM_PAIRS-1:0]   rdReady_out
);

  logic [NUM_PAIRS-1:0] wrFull;
  logic [NUM_PAIRS-1:0] rdEmpty;
  logic [7:0]           rdHead [NUM_PAIRS];
  logic [7:0]           wrStat [NUM_PAIRS];
  logic [7:0]           rdStat [NUM_PAIRS];

  for (genvar k = 0; k < NUM_PAIRS; k++) begin : g_pair
    logic                hitD;
    logic                hitStat;
    logic                hitSR;
    logic                wrEmpty;
    logic                rdFull;
    logic                rdPop;
    logic                ovfSet;
    logic                ovf;
    logic [DEPTH_LOG2:0] wrCnt;
    logic [DEPTH_LOG2:0] rdCnt;

    assign hitD    = hostAddr_in == chanD(BASE_ADDR, k);
    assign hitSR   = hostAddr_in == chanSR(BASE_ADDR, NUM_PAIRS, k);
    assign hitStat = hitSR ||
      hostAddr_in == chanSW(BASE_ADDR, NUM_PAIRS, k);
    assign rdPop   = hostRead_in && hitD;
    assign ovfSet  = rdValid_in[k] && rdFull && !rdPop;

    fifo_sync #(.DEPTH_LOG2(DEPTH_LOG2)) u_wr (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .din       (hostData_in),
      .wr_en     (hostWrite_in && hitD),
      .full      (wrFull[k]),
      .dout      (wrData_out[8*k +: 8]),
      .rd_en     (wrReady_in[k]),
      .empty     (wrEmpty),
      .flush_in  (hostWrite_in && hitStat && hostData_in[FLUSH_WR]),
      .count_out (wrCnt)
    );

    fifo_sync #(.DEPTH_LOG2(DEPTH_LOG2)) u_rd (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .din       (rdData_in[8*k +: 8]),
      .wr_en     (rdValid_in[k]),
      .full      (rdFull),
      .dout      (rdHead[k]),
      .rd_en     (rdPop),
      .empty     (rdEmpty[k]),
      .flush_in  (hostWrite_in && hitStat && hostData_in[FLUSH_RD]),
      .count_out (rdCnt)
    );

    // set beats a same-cycle status-read clear
    always_ff @(posedge clk_in) begin
      if (!reset_in)
        ovf <= 1'b0;
      else if (ovfSet)
        ovf <= 1'b1;
      else if (hostRead_in && hitSR)
        ovf <= 1'b0;
    end

    assign wrValid_out[k] = !wrEmpty;
    assign rdReady_out[k] = !rdFull;
    assign wrStat[k]      = 8'(wrCnt);
    assign rdStat[k]      = {ovf, 1'b0, 6'(rdCnt)};
  end

  always_comb begin
    hostData_out    = 8'h00;
    hostGotRoom_out = 1'b1;
    hostGotData_out = 1'b1;
    for (int k = 0; k < NUM_PAIRS; k++) begin
      if (hostAddr_in == chanD(BASE_ADDR, k)) begin
        hostData_out    = rdHead[k];
        hostGotRoom_out = !wrFull[k];
        hostGotData_out = !rdEmpty[k];
      end
      if (hostAddr_in == chanSW(BASE_ADDR, NUM_PAIRS, k))
        hostData_out = wrStat[k];
      if (hostAddr_in == chanSR(BASE_ADDR, NUM_PAIRS, k))
        hostData_out = rdStat[k];
    end
  end

endmodule

// File: tb/tb_chan_fifo_bridge.sv
// Scoreboard bench for chan_fifo_bridge (2 pairs, depth 4, base 0).
// Channels: D0=0 D1=1 SW0=2 SR0=3 SW1=4 SR1=5.
module tb_chan_fifo_bridge;

  typedef struct {
    string      name;
    logic [7:0] v;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [6:0]  hostAddr_in;
  logic [7:0]  hostData_in;
  logic        hostWrite_in;
  logic        hostGotRoom_out;
  logic [7:0]  hostData_out;
  logic        hostRead_in;
  logic        hostGotData_out;
  logic [15:0] wrData_out;
  logic [1:0]  wrValid_out;
  logic [1:0]  wrReady_in;
  logic [15:0] rdData_in;
  logic [1:0]  rdValid_in;
  logic [1:0]  rdReady_out;

  int checks   = 0;
  int failures = 0;

  exp_t       hostQ[$];
  logic [7:0] appQ0[$];
  logic [7:0] appQ1[$];
  exp_t       he;
  logic [7:0] ae;

  chan_fifo_bridge #(
    .NUM_PAIRS (2),
    .DEPTH_LOG2(2),
    .BASE_ADDR (0)
  ) dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .hostAddr_in     (hostAddr_in),
    .hostData_in     (hostData_in),
    .hostWrite_in    (hostWrite_in),
    .hostGotRoom_out (hostGotRoom_out),
    .hostData_out    (hostData_out),
    .hostRead_in     (hostRead_in),
    .hostGotData_out (hostGotData_out),
    .wrData_out      (wrData_out),
    .wrValid_out     (wrValid_out),
    .wrReady_in      (wrReady_in),
    .rdData_in       (rdData_in),
    .rdValid_in      (rdValid_in),
    .rdReady_out     (rdReady_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string n, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", n, act, exp);
    end
  endtask

  // monitor: compares whatever the DUT presents on a handshake
  always @(negedge clk_in) begin
    if (reset_in && hostRead_in) begin
      if (hostQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL hostRd_unexpected: got %02h expected none",
                 hostData_out);
      end else begin
        he = hostQ.pop_front();
        chk(he.name, hostData_out, he.v);
      end
    end
    if (reset_in && wrReady_in[0] && wrValid_out[0]) begin
      if (appQ0.size() == 0) chk("app0_unexpected", wrData_out[7:0], 8'hxx);
      else begin
        ae = appQ0.pop_front();
        chk("app0_pop", wrData_out[7:0], ae);
      end
    end
    if (reset_in && wrReady_in[1] && wrValid_out[1]) begin
      if (appQ1.size() == 0) chk("app1_unexpected", wrData_out[15:8], 8'hxx);
      else begin
        ae = appQ1.pop_front();
        chk("app1_pop", wrData_out[15:8], ae);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic hostWr(input logic [6:0] a, input logic [7:0] d);
    hostAddr_in  = a;
    hostData_in  = d;
    hostWrite_in = 1'b1;
    tick();
    hostWrite_in = 1'b0;
  endtask

  task automatic hostRd(input logic [6:0] a, input logic [7:0] e,
                        input string n);
    exp_t x;
    x.name = n;
    x.v    = e;
    hostQ.push_back(x);
    hostAddr_in = a;
    hostRead_in = 1'b1;
    tick();
    hostRead_in = 1'b0;
  endtask

  task automatic appPush(input int k, input logic [7:0] d);
    rdData_in[8*k +: 8] = d;
    rdValid_in[k]       = 1'b1;
    tick();
    rdValid_in[k]       = 1'b0;
  endtask

  task automatic appPop(input int k, input logic [7:0] e);
    if (k == 0) appQ0.push_back(e);
    else appQ1.push_back(e);
    wrReady_in[k] = 1'b1;
    tick();
    wrReady_in[k] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in     = 1'b0;
    hostAddr_in  = '0;
    hostData_in  = '0;
    hostWrite_in = 1'b0;
    hostRead_in  = 1'b0;
    wrReady_in   = '0;
    rdData_in    = '0;
    rdValid_in   = '0;
    tick();
    tick();
    reset_in = 1'b1;

    chk("rst_wrValid", {6'd0, wrValid_out}, 8'h00);
    chk("rst_rdReady", {6'd0, rdReady_out}, 8'h03);
    hostRd(7'd2, 8'h00, "rst_SW0");
    hostRd(7'd3, 8'h00, "rst_SR0");

    // pair 1 write path
    hostWr(7'd1, 8'h11);
    chk("p1_wrValid", {7'd0, wrValid_out[1]}, 8'h01);
    chk("p1_head", wrData_out[15:8], 8'h11);
    hostWr(7'd1, 8'h22);
    hostRd(7'd4, 8'h02, "p1_SW");

    // fill write FIFO 0, overfill is dropped
    for (int i = 0; i < 4; i++) hostWr(7'd0, 8'hA0 + 8'(i));
    hostAddr_in = 7'd0;
    #1;
    chk("wr0_gotRoom", {7'd0, hostGotRoom_out}, 8'h00);
    hostWr(7'd0, 8'hA4);
    hostRd(7'd2, 8'h04, "wr0_SW_full");
    for (int i = 0; i < 4; i++) appPop(0, 8'hA0 + 8'(i));
    appPop(1, 8'h11);
    appPop(1, 8'h22);
    hostRd(7'd2, 8'h00, "wr0_SW_drained");
    hostRd(7'd4, 8'h00, "wr1_SW_drained");

    // fill read FIFO 0, overflow sets ovf
    for (int i = 0; i < 4; i++) appPush(0, 8'hB0 + 8'(i));
    chk("rd0_rdReady", {7'd0, rdReady_out[0]}, 8'h00);
    appPush(0, 8'hBF);
    hostRd(7'd3, 8'h84, "SR0_ovf");
    hostRd(7'd3, 8'h04, "SR0_cleared");

    // full FIFO, simultaneous push and pop
    hostQ.push_back('{name: "rd0_pop_full", v: 8'hB0});
    hostAddr_in   = 7'd0;
    hostRead_in   = 1'b1;
    rdData_in[7:0] = 8'hC0;
    rdValid_in[0] = 1'b1;
    tick();
    hostRead_in   = 1'b0;
    rdValid_in[0] = 1'b0;
    hostRd(7'd3, 8'h04, "SR0_pushpop");
    hostRd(7'd0, 8'hB1, "rd0_pop1");
    hostRd(7'd0, 8'hB2, "rd0_pop2");
    hostRd(7'd0, 8'hB3, "rd0_pop3");
    hostRd(7'd0, 8'hC0, "rd0_pop4");
    hostAddr_in = 7'd0;
    #1;
    chk("rd0_gotData_empty", {7'd0, hostGotData_out}, 8'h00);

    // flush both FIFOs of pair 0 with a racing push
    hostWr(7'd0, 8'h55);
    appPush(0, 8'h66);
    hostRd(7'd2, 8'h01, "SW0_preflush");
    rdData_in[7:0] = 8'h77;
    rdValid_in[0]  = 1'b1;
    hostWr(7'd2, 8'h03);
    rdValid_in[0]  = 1'b0;
    hostRd(7'd2, 8'h00, "SW0_flushed");
    hostRd(7'd3, 8'h00, "SR0_flushed");
    hostAddr_in = 7'd0;
    #1;
    chk("flush_gotData", {7'd0, hostGotData_out}, 8'h00);
    chk("flush_wrValid0", {7'd0, wrValid_out[0]}, 8'h00);

    // unmapped channels
    hostWr(7'd6, 8'hFF);
    hostRd(7'd10, 8'h00, "unmapped_rd");
    chk("unmapped_gotRoom", {7'd0, hostGotRoom_out}, 8'h01);
    hostRd(7'd4, 8'h00, "SW1_after_unmapped");

    // reset mid-burst
    hostWr(7'd1, 8'h01);
    appPush(1, 8'h02);
    hostAddr_in  = 7'd1;
    hostData_in  = 8'h03;
    hostWrite_in = 1'b1;
    rdValid_in[1] = 1'b1;
    reset_in     = 1'b0;
    tick();
    hostWrite_in  = 1'b0;
    rdValid_in[1] = 1'b0;
    reset_in      = 1'b1;
    chk("rst2_rdReady", {6'd0, rdReady_out}, 8'h03);
    chk("rst2_wrValid", {6'd0, wrValid_out}, 8'h00);
    hostRd(7'd2, 8'h00, "rst2_SW0");
    hostRd(7'd3, 8'h00, "rst2_SR0");
    hostRd(7'd4, 8'h00, "rst2_SW1");
    hostRd(7'd5, 8'h00, "rst2_SR1");

    tick();
    chk("hostQ_left", 8'(hostQ.size()), 8'h00);
    chk("appQ_left", 8'(appQ0.size() + appQ1.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
